// File: rtl/ibex_wbq_pkg.sv
// ibex_wbq_pkg
// Shared definitions for the register-file write-back queue.
//   WbqMaxPush     : most entries that can be enqueued in one cycle.
//   WbqDataWidth   : default write-back data width.
//   wbq_entry_t    : one queued write-back (destination register + data).
//   wbq_free_slots : free entries from a depth and an occupancy count.
package ibex_wbq_pkg;

  localparam int unsigned WbqMaxPush   = 32'd2;
  localparam int unsigned WbqDataWidth = 32'd32;

  typedef struct packed {
    logic [4:0]              addr;
    logic [WbqDataWidth-1:0] data;
  } wbq_entry_t;

  // Saturates at zero so an out-of-range count can never read as spare room.
  function automatic int unsigned wbq_free_slots(input int unsigned depth,
                                                 input int unsigned count);
    if (count >= depth) begin
      return 32'd0;
    end else begin
      return depth - count;
    end
  endfunction

endpackage

// File: rtl/ibex_rf_wb_queue_if.sv
// ibex_rf_wb_queue_if
// Handshake and register-file bus of the write-back queue.
//   lsu_* : LSU write-back request (req/addr/wdata) and its grant.
//   ex_*  : EX write-back request (req/addr/wdata) and its grant.
//   rf_*  : register file write port (we/waddr/wdata).
// master: the producer / register-file side.
// slave : the queue itself.
interface ibex_rf_wb_queue_if #(
  parameter int unsigned DataWidth = 32
) ();

  logic                 lsu_req;
  logic [4:0]           lsu_addr;
  logic [DataWidth-1:0] lsu_wdata;
  logic                 lsu_gnt;

  logic                 ex_req;
  logic [4:0]           ex_addr;
  logic [DataWidth-1:0] ex_wdata;
  logic                 ex_gnt;

  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;

  modport master (
    output lsu_req, lsu_addr, lsu_wdata, ex_req, ex_addr, ex_wdata,
    input  lsu_gnt, ex_gnt, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  lsu_req, lsu_addr, lsu_wdata, ex_req, ex_addr, ex_wdata,
    output lsu_gnt, ex_gnt, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/ibex_wbq_fifo.sv
// ibex_wbq_fifo
// Circular buffer accepting up to two pushes and one pop per cycle.
//   clk_i, rst_i          : clock, asynchronous active-high reset.
//   push0_i/push0_data_i  : first (older) entry to enqueue.
//   push1_i/push1_data_i  : second entry; only honoured together with push0_i.
//   pop_i                 : remove the head entry (ignored when empty).
//   head_o                : head entry, straight from storage.
//   count_o               : occupied entries.
//   valid_o/entries_o     : per-slot occupancy and raw storage for lookups.
// The caller guarantees pushes never exceed free space.
module ibex_wbq_fifo
  import ibex_wbq_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 37
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push0_i,
  input  logic [Width-1:0]        push0_data_i,
  input  logic                    push1_i,
  input  logic [Width-1:0]        push1_data_i,
  input  logic                    pop_i,
  output logic [Width-1:0]        head_o,
  output logic [$clog2(Depth):0]  count_o,
  output logic [Depth-1:0]        valid_o,
  output logic [Width-1:0]        entries_o [Depth]
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop_s;
  logic             push1_s;

  assign pop_s   = pop_i && (count_q != {CntW{1'b0}});
  assign push1_s = push0_i && push1_i;

  // Next-state for storage, pointers and occupancy; pointers wrap by width.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (push0_i) begin
      mem_d[wptr_q] = push0_data_i;
      if (push1_s) begin
        mem_d[wptr_q + PtrW'(1)] = push1_data_i;
        wptr_d = wptr_q + PtrW'(2);
      end else begin
        wptr_d = wptr_q + PtrW'(1);
      end
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PtrW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    count_d = count_q + CntW'(push0_i) + CntW'(push1_s) - CntW'(pop_s);
  end

  // State registers; reset empties the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= {PtrW{1'b0}};
      rptr_q  <= {PtrW{1'b0}};
      count_q <= {CntW{1'b0}};
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= {Width{1'b0}};
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Slot i is live when its distance from the head is below the count.
  always_comb begin
    valid_o = {Depth{1'b0}};
    for (int i = 0; i < Depth; i++) begin
      valid_o[i] = ({1'b0, PtrW'(i) - rptr_q}) < count_q;
    end
  end

  assign head_o    = mem_q[rptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/ibex_rf_wb_queue.sv
// ibex_rf_wb_queue
// In-order write-back queue in front of the single register-file write port.
//   clk_i, rst_i         : clock, asynchronous active-high reset.
//   wb (slave)           : LSU / EX write-back handshakes and rf write port.
//   raddr_a_i/raddr_b_i  : ID read addresses.
//   pending_a_o/_b_o     : a queued write targets that read address.
//   count_o              : occupied entries.
//   err_o                : registered pulse, illegal RV32E address accepted.
// LSU wins arbitration and is enqueued ahead of EX when both are granted.
// x0 and illegal RV32E writes are granted but dropped. The head drains every
// cycle the queue is non-empty; the register file cannot stall it.
module ibex_rf_wb_queue
  import ibex_wbq_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ibex_rf_wb_queue_if.slave      wb,
  input  logic [4:0]             raddr_a_i,
  input  logic [4:0]             raddr_b_i,
  output logic                   pending_a_o,
  output logic                   pending_b_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   err_o
);

  localparam int unsigned CntW   = $clog2(Depth) + 1;
  localparam int unsigned EntryW = 5 + DataWidth;

  typedef struct packed {
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  logic [CntW-1:0]   count_s;
  int unsigned       free_s;
  logic              lsu_gnt_s, ex_gnt_s;
  logic              lsu_legal_s, ex_legal_s;
  logic              lsu_push_s, ex_push_s;
  logic              push0_s, push1_s, pop_s;
  entry_t            lsu_entry_s, ex_entry_s, push0_entry_s, head_s;
  logic [EntryW-1:0] fifo_head_s;
  logic [EntryW-1:0] fifo_mem_s [Depth];
  logic [Depth-1:0]  fifo_valid_s;
  logic              pend_a_s, pend_b_s;
  logic              err_d, err_q;

  // Credit comes from the registered count only; a same-cycle pop adds none.
  assign free_s = wbq_free_slots(Depth, 32'(count_s));

  // Arbitration: LSU first, EX only if room remains after a possible LSU push.
  always_comb begin
    lsu_gnt_s = 1'b0;
    ex_gnt_s  = 1'b0;
    if (rst_i) begin
      lsu_gnt_s = 1'b0;
      ex_gnt_s  = 1'b0;
    end else begin
      lsu_gnt_s = wb.lsu_req && (free_s >= 32'd1);
      ex_gnt_s  = wb.ex_req && ((free_s >= WbqMaxPush) ||
                                ((free_s >= 32'd1) && !wb.lsu_req));
    end
  end

  // Drop x0 and illegal writes; compact surviving pushes so slot 0 is oldest.
  always_comb begin
    lsu_legal_s       = !(RV32E && wb.lsu_addr[4]);
    ex_legal_s        = !(RV32E && wb.ex_addr[4]);
    lsu_push_s        = lsu_gnt_s && (wb.lsu_addr != 5'd0) && lsu_legal_s;
    ex_push_s         = ex_gnt_s && (wb.ex_addr != 5'd0) && ex_legal_s;
    lsu_entry_s.addr  = wb.lsu_addr;
    lsu_entry_s.data  = wb.lsu_wdata;
    ex_entry_s.addr   = wb.ex_addr;
    ex_entry_s.data   = wb.ex_wdata;
    push0_s           = lsu_push_s || ex_push_s;
    push1_s           = lsu_push_s && ex_push_s;
    push0_entry_s     = lsu_push_s ? lsu_entry_s : ex_entry_s;
    err_d             = RV32E ? ((lsu_gnt_s && !lsu_legal_s) ||
                                 (ex_gnt_s && !ex_legal_s)) : 1'b0;
  end

  assign pop_s = (count_s != {CntW{1'b0}});

  ibex_wbq_fifo #(
    .Depth (Depth),
    .Width (EntryW)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push0_i      (push0_s),
    .push0_data_i (push0_entry_s),
    .push1_i      (push1_s),
    .push1_data_i (ex_entry_s),
    .pop_i        (pop_s),
    .head_o       (fifo_head_s),
    .count_o      (count_s),
    .valid_o      (fifo_valid_s),
    .entries_o    (fifo_mem_s)
  );

  assign head_s = fifo_head_s;

  // Register-file port: head entry while non-empty, all zeros otherwise.
  always_comb begin
    wb.rf_we = pop_s;
    if (pop_s) begin
      wb.rf_waddr = head_s.addr;
      wb.rf_wdata = head_s.data;
    end else begin
      wb.rf_waddr = 5'd0;
      wb.rf_wdata = {DataWidth{1'b0}};
    end
  end

  // Pending lookup over live entries, including the head being written now.
  always_comb begin
    pend_a_s = 1'b0;
    pend_b_s = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      pend_a_s = pend_a_s | (fifo_valid_s[i] &&
                             (fifo_mem_s[i][EntryW-1 -: 5] == raddr_a_i));
      pend_b_s = pend_b_s | (fifo_valid_s[i] &&
                             (fifo_mem_s[i][EntryW-1 -: 5] == raddr_b_i));
    end
    pending_a_o = pend_a_s && (raddr_a_i != 5'd0);
    pending_b_o = pend_b_s && (raddr_b_i != 5'd0);
  end

  // Error pulse register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign wb.lsu_gnt = lsu_gnt_s;
  assign wb.ex_gnt  = ex_gnt_s;
  assign count_o    = count_s;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ibex_rf_wb_queue.sv
module tb_ibex_rf_wb_queue;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raddr_a, raddr_b;
  logic       pend_a, pend_b, pend0_a, pend0_b, err, err0;
  logic [2:0] count, count0;

  always #5 clk = ~clk;

  ibex_rf_wb_queue_if #(.DataWidth(DW)) wb  ();
  ibex_rf_wb_queue_if #(.DataWidth(DW)) wb0 ();

  ibex_rf_wb_queue #(.DataWidth(DW), .Depth(DEPTH), .RV32E(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .wb(wb), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .pending_a_o(pend_a), .pending_b_o(pend_b), .count_o(count), .err_o(err));

  ibex_rf_wb_queue #(.DataWidth(DW), .Depth(DEPTH), .RV32E(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wb(wb0), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .pending_a_o(pend0_a), .pending_b_o(pend0_b), .count_o(count0), .err_o(err0));

  // Reference model: ordered list of outstanding register writes.
  ent_t mq[$];
  logic exp_err;
  int   checks = 0;
  int   errors = 0;

  function automatic int free_m();
    return int'(DEPTH) - mq.size();
  endfunction

  function automatic bit exp_lsu_gnt();
    return !rst && wb.lsu_req && (free_m() >= 1);
  endfunction

  function automatic bit exp_ex_gnt();
    return !rst && wb.ex_req && ((free_m() >= 2) || ((free_m() >= 1) && !wb.lsu_req));
  endfunction

  function automatic bit exp_pending(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].addr == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit keeps(input logic [4:0] a);
    return (a != 5'd0) && !a[4];
  endfunction

  // {lsu_gnt, ex_gnt, count, we, waddr, wdata, pend_a, pend_b, err}
  function automatic logic [45:0] obs_vec();
    return {wb.lsu_gnt, wb.ex_gnt, count, wb.rf_we, wb.rf_waddr, wb.rf_wdata,
            pend_a, pend_b, err};
  endfunction

  function automatic logic [45:0] exp_vec();
    ent_t h;
    h = '{addr: 5'd0, data: 32'd0};
    if (mq.size() != 0) h = mq[0];
    return {exp_lsu_gnt(), exp_ex_gnt(), 3'(mq.size()), mq.size() != 0, h.addr, h.data,
            exp_pending(raddr_a), exp_pending(raddr_b), exp_err};
  endfunction

  // One clock: capture expected grants, advance model at the edge, return at negedge.
  task automatic tick(output bit lg, output bit eg);
    lg = exp_lsu_gnt();
    eg = exp_ex_gnt();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_err = 1'b0;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      exp_err = (lg && wb.lsu_addr[4]) || (eg && wb.ex_addr[4]);
      if (lg && keeps(wb.lsu_addr)) mq.push_back('{addr: wb.lsu_addr, data: wb.lsu_wdata});
      if (eg && keeps(wb.ex_addr)) mq.push_back('{addr: wb.ex_addr, data: wb.ex_wdata});
    end
    @(negedge clk);
  endtask

  task automatic step();
    bit lg, eg;
    tick(lg, eg);
  endtask

  task automatic set_lsu(input bit req, input logic [4:0] a, input logic [31:0] d);
    wb.lsu_req = req; wb.lsu_addr = a; wb.lsu_wdata = d;
  endtask

  task automatic set_ex(input bit req, input logic [4:0] a, input logic [31:0] d);
    wb.ex_req = req; wb.ex_addr = a; wb.ex_wdata = d;
  endtask

  task automatic drain();
    set_lsu(1'b0, 5'd0, 32'd0);
    set_ex(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 16 && mq.size() != 0; k++) step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_lsu(1'b1, 5'd5, 32'h1); set_ex(1'b1, 5'd6, 32'h2);
    wb0.lsu_req = 1'b0; wb0.lsu_addr = 5'd0; wb0.lsu_wdata = 32'd0;
    wb0.ex_req = 1'b0; wb0.ex_addr = 5'd0; wb0.ex_wdata = 32'd0;
    raddr_a = 5'd5; raddr_b = 5'd6;
    mq.delete(); exp_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (wb.lsu_gnt !== 1'b0 || wb.ex_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got %b%b, expected 00", wb.lsu_gnt, wb.ex_gnt);
    end
    checks++;
    if (obs_vec() !== 46'd0) begin
      errors++; $display("FAIL reset_outputs: got %h, expected 0", obs_vec());
    end
    set_lsu(1'b0, 5'd0, 32'd0); set_ex(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_lsu();
    set_lsu(1'b1, 5'd5, 32'hDEADBEEF); raddr_a = 5'd5; raddr_b = 5'd0;
    #1;
    checks++;
    if (wb.lsu_gnt !== 1'b1 || pend_a !== 1'b0) begin
      errors++; $display("FAIL single_gnt: got gnt=%b pend=%b, expected gnt=1 pend=0", wb.lsu_gnt, pend_a);
    end
    step();
    set_lsu(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({wb.rf_we, wb.rf_waddr, wb.rf_wdata, pend_a, count} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 3'd1}) begin
      errors++; $display("FAIL single_drain: got we=%b a=%0d d=%h p=%b c=%0d, expected 1 5 deadbeef 1 1",
                         wb.rf_we, wb.rf_waddr, wb.rf_wdata, pend_a, count);
    end
    step();
    #1;
    checks++;
    if (pend_a !== 1'b0 || wb.rf_we !== 1'b0) begin
      errors++; $display("FAIL single_after: got pend=%b we=%b, expected 0 0", pend_a, wb.rf_we);
    end
  endtask

  task automatic test_dual_push();
    set_lsu(1'b1, 5'd3, 32'h11); set_ex(1'b1, 5'd3, 32'h22); raddr_b = 5'd3;
    #1;
    checks++;
    if (wb.lsu_gnt !== 1'b1 || wb.ex_gnt !== 1'b1) begin
      errors++; $display("FAIL dual_gnt: got %b%b, expected 11", wb.lsu_gnt, wb.ex_gnt);
    end
    step();
    set_lsu(1'b0, 5'd0, 32'd0); set_ex(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({count, wb.rf_waddr, wb.rf_wdata, pend_b} !== {3'd2, 5'd3, 32'h11, 1'b1}) begin
      errors++; $display("FAIL dual_first: got c=%0d a=%0d d=%h p=%b, expected 2 3 11 1", count, wb.rf_waddr, wb.rf_wdata, pend_b);
    end
    step();
    #1;
    checks++;
    if ({count, wb.rf_we, wb.rf_waddr, wb.rf_wdata} !== {3'd1, 1'b1, 5'd3, 32'h22}) begin
      errors++; $display("FAIL dual_second: got c=%0d we=%b a=%0d d=%h, expected 1 1 3 22", count, wb.rf_we, wb.rf_waddr, wb.rf_wdata);
    end
    step();
    #1;
    checks++;
    if (count !== 3'd0 || wb.rf_we !== 1'b0) begin
      errors++; $display("FAIL dual_empty: got c=%0d we=%b, expected 0 0", count, wb.rf_we);
    end
  endtask

  task automatic test_priority();
    set_lsu(1'b1, 5'd1, 32'hA1); set_ex(1'b1, 5'd2, 32'hA2);
    step();
    set_lsu(1'b1, 5'd4, 32'hA4); set_ex(1'b1, 5'd6, 32'hA6);
    step();
    set_lsu(1'b1, 5'd7, 32'hA7); set_ex(1'b1, 5'd9, 32'hA9);
    #1;
    checks++;
    if ({count, wb.lsu_gnt, wb.ex_gnt} !== {3'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL prio_free1: got c=%0d gnt=%b%b, expected 3 10", count, wb.lsu_gnt, wb.ex_gnt);
    end
    step();
    set_lsu(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({count, wb.ex_gnt, wb.rf_waddr} !== {3'd3, 1'b1, 5'd4}) begin
      errors++; $display("FAIL prio_ex_next: got c=%0d ex_gnt=%b head=%0d, expected 3 1 4", count, wb.ex_gnt, wb.rf_waddr);
    end
    step();
    drain();
  endtask

  task automatic test_saturation();
    bit lg, eg;
    logic [4:0] la, ea;
    la = 5'd10; ea = 5'd11;
    for (int c = 0; c < 8; c++) begin
      set_lsu(1'b1, la, 32'(c)); set_ex(1'b1, ea, 32'(c + 100));
      #1;
      checks++;
      if ({wb.lsu_gnt, wb.ex_gnt, count} !== {exp_lsu_gnt(), exp_ex_gnt(), 3'(mq.size())}) begin
        errors++; $display("FAIL sat_cycle%0d: got gnt=%b%b c=%0d, expected gnt=%b%b c=%0d", c,
                           wb.lsu_gnt, wb.ex_gnt, count, exp_lsu_gnt(), exp_ex_gnt(), mq.size());
      end
      tick(lg, eg);
      if (lg) la = (la == 5'd14) ? 5'd10 : la + 5'd1;
      if (eg) ea = (ea == 5'd14) ? 5'd10 : ea + 5'd1;
    end
    #1;
    checks++;
    if (count !== 3'(DEPTH - 1)) begin
      errors++; $display("FAIL sat_plateau: got c=%0d, expected %0d", count, DEPTH - 1);
    end
    drain();
  endtask

  task automatic test_x0_illegal();
    set_ex(1'b1, 5'd0, 32'h99);
    #1;
    checks++;
    if (wb.ex_gnt !== 1'b1) begin
      errors++; $display("FAIL x0_gnt: got %b, expected 1", wb.ex_gnt);
    end
    step();
    set_ex(1'b1, 5'd20, 32'h20);
    #1;
    checks++;
    if ({count, wb.rf_we, err, wb.ex_gnt} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL x0_dropped: got c=%0d we=%b err=%b gnt=%b, expected 0 0 0 1", count, wb.rf_we, err, wb.ex_gnt);
    end
    step();
    set_ex(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({err, count, wb.rf_we} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL illegal_err: got err=%b c=%0d we=%b, expected 1 0 0", err, count, wb.rf_we);
    end
    step();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: got err=%b, expected 0", err);
    end
    set_lsu(1'b1, 5'd16, 32'h16); set_ex(1'b1, 5'd7, 32'h77);
    step();
    set_lsu(1'b0, 5'd0, 32'd0); set_ex(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({err, count, wb.rf_waddr, wb.rf_wdata} !== {1'b1, 3'd1, 5'd7, 32'h77}) begin
      errors++; $display("FAIL illegal_mixed: got err=%b c=%0d a=%0d d=%h, expected 1 1 7 77", err, count, wb.rf_waddr, wb.rf_wdata);
    end
    drain();
  endtask

  task automatic test_rv32e_off();
    wb0.ex_req = 1'b1; wb0.ex_addr = 5'd20; wb0.ex_wdata = 32'h55;
    #1;
    checks++;
    if (wb0.ex_gnt !== 1'b1) begin
      errors++; $display("FAIL e0_gnt: got %b, expected 1", wb0.ex_gnt);
    end
    step();
    wb0.ex_req = 1'b0;
    #1;
    checks++;
    if ({count0, wb0.rf_waddr, wb0.rf_wdata, err0} !== {3'd1, 5'd20, 32'h55, 1'b0}) begin
      errors++; $display("FAIL e0_kept: got c=%0d a=%0d d=%h err=%b, expected 1 20 55 0", count0, wb0.rf_waddr, wb0.rf_wdata, err0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    set_lsu(1'b1, 5'd1, 32'hB1); set_ex(1'b1, 5'd2, 32'hB2);
    step();
    set_lsu(1'b1, 5'd3, 32'hB3); set_ex(1'b1, 5'd4, 32'hB4);
    step();
    set_lsu(1'b1, 5'd8, 32'hB8); set_ex(1'b1, 5'd9, 32'hB9);
    raddr_a = 5'd3; raddr_b = 5'd4;
    #1;
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL rstmid_pre: got c=%0d, expected 3", count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 46'd0) begin
      errors++; $display("FAIL rstmid_async: got %h, expected 0", obs_vec());
    end
    mq.delete(); exp_err = 1'b0;
    @(negedge clk);
    set_lsu(1'b0, 5'd0, 32'd0); set_ex(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
    checks++;
    if ({wb.rf_we, count} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL rstmid_release: got we=%b c=%0d, expected 0 0", wb.rf_we, count);
    end
    step();
    set_lsu(1'b1, 5'd12, 32'hC12);
    #1;
    checks++;
    if ({wb.rf_we, wb.lsu_gnt} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL rstmid_after: got we=%b gnt=%b, expected 0 1", wb.rf_we, wb.lsu_gnt);
    end
    step();
    drain();
  endtask

  task automatic test_random();
    bit lsu_busy, ex_busy, lg, eg;
    lsu_busy = 1'b0; ex_busy = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!lsu_busy) begin
        wb.lsu_req   = ($urandom_range(0, 9) < 6);
        wb.lsu_addr  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
        wb.lsu_wdata = $urandom();
        lsu_busy     = wb.lsu_req;
      end
      if (!ex_busy) begin
        wb.ex_req   = ($urandom_range(0, 9) < 7);
        wb.ex_addr  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
        wb.ex_wdata = $urandom();
        ex_busy     = wb.ex_req;
      end
      raddr_a = 5'($urandom_range(0, 15));
      raddr_b = 5'($urandom_range(0, 15));
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec());
      end
      tick(lg, eg);
      if (lg) lsu_busy = 1'b0;
      if (eg) ex_busy = 1'b0;
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_lsu();
    test_dual_push();
    test_priority();
    test_saturation();
    test_x0_illegal();
    test_rv32e_off();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
